// File: rtl/ts_int_sched_if.sv
// ts_int_sched_if: raster/strobe inputs, register write port and interrupt
// strobe outputs of the raster interrupt scheduler, grouped as one bundle.
// The master side drives raster timing and register writes; the slave side
// (the scheduler) returns the INT start strobes, INTMASK and the line number.
interface ts_int_sched_if #(
    parameter int VCNT_W  = 9,
    parameter int HSINT_W = 8
);
    logic               line_start;
    logic               frame_start;
    logic [HSINT_W-1:0] hcnt;
    logic               dma_done;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               int_start_frm;
    logic               int_start_lin;
    logic               int_start_dma;
    logic [7:0]         intmask;
    logic [VCNT_W-1:0]  vline;

    modport master (
        output line_start, frame_start, hcnt, dma_done, wr_en, wr_addr, wr_data,
        input  int_start_frm, int_start_lin, int_start_dma, intmask, vline
    );

    modport slave (
        input  line_start, frame_start, hcnt, dma_done, wr_en, wr_addr, wr_data,
        output int_start_frm, int_start_lin, int_start_dma, intmask, vline
    );
endinterface

// File: rtl/ts_int_sched.sv
// ts_int_sched: raster-position interrupt scheduler feeding the Z80 interrupt
// controller. Tracks the video line, raises a frame INT when the raster reaches
// the programmed (VSINT, HSINT) point, raises line INTs (optionally decimated by
// LSTEP) and turns the DMA-complete edge into a strobe. Also holds INTMASK.
//
// Build option: define INT_SCHED_LSTEP_EN to implement the LSTEP register and
// the line-INT decimation counter. Without it every line start produces a line
// INT and register address 4 is ignored.
//
// VSINT is written as a low byte (address 1) plus bit 8 (address 2), so VCNT_W
// is expected to be 9.
module ts_int_sched #(
    parameter int VCNT_W  = 9,
    parameter int VTOTAL  = 320,
    parameter int HSINT_W = 8
) (
    input  logic          clk,
    input  logic          res,
    ts_int_sched_if.slave bus
);
    localparam logic [VCNT_W-1:0] LP_VLAST  = VCNT_W'(VTOTAL - 1);
    localparam logic [VCNT_W:0]   LP_VTOTAL = (VCNT_W + 1)'(VTOTAL);
    localparam logic [VCNT_W-1:0] LP_VZERO  = VCNT_W'(0);
    localparam logic [VCNT_W-1:0] LP_VONE   = VCNT_W'(1);

    localparam logic [2:0] LP_A_HSINT = 3'd0;
    localparam logic [2:0] LP_A_VSLO  = 3'd1;
    localparam logic [2:0] LP_A_VSHI  = 3'd2;
    localparam logic [2:0] LP_A_MASK  = 3'd3;

    logic [HSINT_W-1:0] r_hsint;
    logic [VCNT_W-1:0]  r_vsint;
    logic [7:0]         r_intmask;
    logic [VCNT_W-1:0]  r_vline;
    logic [VCNT_W-1:0]  w_vline_nxt;
    logic               r_frm_hit;
    logic               r_dma;
    logic               r_int_frm;
    logic               r_int_lin;
    logic               r_int_dma;
    logic               w_vsint_ok;
    logic               w_frm_hit;
    logic               w_lin_fire;
    logic               w_dma_rise;

    // Configuration registers; a write becomes visible on the cycle after the strobe.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_hsint   <= {HSINT_W{1'b0}};
            r_vsint   <= {VCNT_W{1'b0}};
            r_intmask <= 8'h01;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                LP_A_HSINT: r_hsint      <= HSINT_W'(bus.wr_data);
                LP_A_VSLO:  r_vsint[7:0] <= bus.wr_data;
                LP_A_VSHI:  r_vsint[8]   <= bus.wr_data[0];
                LP_A_MASK:  r_intmask    <= bus.wr_data;
                default:    ;
            endcase
        end
    end

    // Next line number: frame start forces line 0, a line start advances and wraps.
    always_comb begin
        w_vline_nxt = r_vline;
        if (bus.frame_start) begin
            w_vline_nxt = LP_VZERO;
        end else if (bus.line_start) begin
            if (r_vline == LP_VLAST) begin
                w_vline_nxt = LP_VZERO;
            end else begin
                w_vline_nxt = r_vline + LP_VONE;
            end
        end else begin
            w_vline_nxt = r_vline;
        end
    end

    // Line counter register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_vline <= {VCNT_W{1'b0}};
        end else begin
            r_vline <= w_vline_nxt;
        end
    end

    // A VSINT beyond the last line can never be reached, so it never matches.
    assign w_vsint_ok = ({1'b0, r_vsint} < LP_VTOTAL);
    assign w_frm_hit  = w_vsint_ok && (r_vline == r_vsint) && (bus.hcnt == r_hsint);
    assign w_dma_rise = bus.dma_done && !r_dma;

`ifdef INT_SCHED_LSTEP_EN
    localparam logic [2:0] LP_A_LSTEP = 3'd4;

    logic [7:0] r_lstep;
    logic [7:0] r_lctr;
    logic [7:0] w_lctr_nxt;

    // LSTEP register; a new step is only picked up at the next counter reload.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_lstep <= 8'h00;
        end else if (bus.wr_en && (bus.wr_addr == LP_A_LSTEP)) begin
            r_lstep <= bus.wr_data;
        end
    end

    // Line decimation: frame start always fires and reloads; other lines fire when the countdown is spent.
    always_comb begin
        w_lin_fire = 1'b0;
        w_lctr_nxt = r_lctr;
        if (bus.frame_start) begin
            w_lin_fire = 1'b1;
            w_lctr_nxt = r_lstep;
        end else if (bus.line_start) begin
            if (r_lctr == 8'h00) begin
                w_lin_fire = 1'b1;
                w_lctr_nxt = r_lstep;
            end else begin
                w_lin_fire = 1'b0;
                w_lctr_nxt = r_lctr - 8'h01;
            end
        end else begin
            w_lin_fire = 1'b0;
            w_lctr_nxt = r_lctr;
        end
    end

    // Line-step countdown register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_lctr <= 8'h00;
        end else begin
            r_lctr <= w_lctr_nxt;
        end
    end
`else
    // No decimation: every line start (including the frame's first line) fires.
    always_comb begin
        w_lin_fire = bus.frame_start || bus.line_start;
    end
`endif

    // Edge history for the frame match and the DMA busy level.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_frm_hit <= 1'b0;
            r_dma     <= 1'b0;
        end else begin
            r_frm_hit <= w_frm_hit;
            r_dma     <= bus.dma_done;
        end
    end

    // Single-cycle INT start strobes, one clock after their triggering condition.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_int_frm <= 1'b0;
            r_int_lin <= 1'b0;
            r_int_dma <= 1'b0;
        end else begin
            r_int_frm <= w_frm_hit && !r_frm_hit;
            r_int_lin <= w_lin_fire;
            r_int_dma <= w_dma_rise;
        end
    end

    assign bus.int_start_frm = r_int_frm;
    assign bus.int_start_lin = r_int_lin;
    assign bus.int_start_dma = r_int_dma;
    assign bus.intmask       = r_intmask;
    assign bus.vline         = r_vline;
endmodule

// File: tb/tb_ts_int_sched.sv
// tb_ts_int_sched: scoreboard bench for ts_int_sched. A driver applies one set
// of inputs per cycle on the falling edge, asks a behavioural model what the
// outputs must be after the next rising edge and queues that expectation; a
// monitor pops and compares shortly after each rising edge.
module tb_ts_int_sched;
    localparam int VCNT_W  = 9;
    localparam int VTOTAL  = 320;
    localparam int HSINT_W = 8;
`ifdef INT_SCHED_LSTEP_EN
    localparam int LIN_EXP = 4;
`else
    localparam int LIN_EXP = 10;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    ts_int_sched_if #(.VCNT_W(VCNT_W), .HSINT_W(HSINT_W)) bus ();

    ts_int_sched #(.VCNT_W(VCNT_W), .VTOTAL(VTOTAL), .HSINT_W(HSINT_W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    typedef struct {
        bit frm;
        bit lin;
        bit dma;
        int vline;
        int intmask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cnt_frm  = 0;
    int   cnt_lin  = 0;
    int   cnt_dma  = 0;

    // staged stimulus for the next cycle
    bit         s_fs, s_ls, s_we, s_dma;
    logic [7:0] s_hcnt, s_wd;
    logic [2:0] s_wa;

    // reference model state (values valid during the current cycle)
    int m_vline, m_hsint, m_vsint, m_lstep, m_intmask, m_idx, m_next_fire;
    bit m_match_prev, m_dma_prev;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_vline      = 0;
        m_hsint      = 0;
        m_vsint      = 0;
        m_lstep      = 0;
        m_intmask    = 1;
        m_idx        = 0;
        m_next_fire  = 1;  // step counter starts at 0: the first line start fires
        m_match_prev = 1'b0;
        m_dma_prev   = 1'b0;
        sb_q.delete();
    endtask

    // Apply staged inputs for one cycle and queue the expected post-edge outputs.
    task automatic tick();
        exp_t e;
        bit   match;
        bit   fire;
        @(negedge clk);
        bus.frame_start = s_fs;
        bus.line_start  = s_ls;
        bus.hcnt        = s_hcnt;
        bus.dma_done    = s_dma;
        bus.wr_en       = s_we;
        bus.wr_addr     = s_wa;
        bus.wr_data     = s_wd;

        match        = (m_vline == m_vsint) && (int'(s_hcnt) == m_hsint);
        e.frm        = match && !m_match_prev;
        m_match_prev = match;

        fire = 1'b0;
`ifdef INT_SCHED_LSTEP_EN
        if (s_fs) begin
            fire        = 1'b1;
            m_idx       = 0;
            m_next_fire = m_lstep + 1;
        end else if (s_ls) begin
            m_idx++;
            if (m_idx == m_next_fire) begin
                fire        = 1'b1;
                m_next_fire = m_idx + m_lstep + 1;
            end
        end
`else
        fire = s_fs || s_ls;
`endif
        e.lin = fire;

        e.dma      = s_dma && !m_dma_prev;
        m_dma_prev = s_dma;

        if (s_fs) m_vline = 0;
        else if (s_ls) m_vline = (m_vline + 1) % VTOTAL;

        if (s_we) begin
            case (s_wa)
                3'd0: m_hsint   = int'(s_wd);
                3'd1: m_vsint   = (m_vsint & 256) | int'(s_wd);
                3'd2: m_vsint   = (m_vsint & 255) | (int'(s_wd[0]) << 8);
                3'd3: m_intmask = int'(s_wd);
`ifdef INT_SCHED_LSTEP_EN
                3'd4: m_lstep   = int'(s_wd);
`endif
                default: ;
            endcase
        end

        e.vline   = m_vline;
        e.intmask = m_intmask;
        sb_q.push_back(e);
        s_fs = 1'b0;
        s_ls = 1'b0;
        s_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        s_we = 1'b1;
        s_wa = a;
        s_wd = d;
        tick();
    endtask

    // One video line of len cycles, hcnt counting from 0.
    task automatic run_line(input bit fs, input int len);
        s_ls = 1'b1;
        s_fs = fs;
        for (int h = 0; h < len; h++) begin
            s_hcnt = 8'(h);
            tick();
        end
    endtask

    // Let the monitor consume the expectation of the last driven cycle.
    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!res) begin
                if (bus.int_start_frm) cnt_frm++;
                if (bus.int_start_lin) cnt_lin++;
                if (bus.int_start_dma) cnt_dma++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_frm", int'(bus.int_start_frm), int'(e.frm));
                    check("sb_lin", int'(bus.int_start_lin), int'(e.lin));
                    check("sb_dma", int'(bus.int_start_dma), int'(e.dma));
                    check("sb_vline", int'(bus.vline), e.vline);
                    check("sb_intmask", int'(bus.intmask), e.intmask);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, actual %0t required below 2000000", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        s_fs = 1'b0; s_ls = 1'b0; s_we = 1'b0; s_dma = 1'b0;
        s_hcnt = 8'd200; s_wa = 3'd0; s_wd = 8'h00;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.hcnt        = 8'd200;
        bus.dma_done    = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = 3'd0;
        bus.wr_data     = 8'h00;
        model_reset();

        // power-on reset
        #1 res = 1'b1;
        #1;
        check("por_vline", int'(bus.vline), 0);
        check("por_intmask", int'(bus.intmask), 1);
        check("por_frm", int'(bus.int_start_frm), 0);
        check("por_lin", int'(bus.int_start_lin), 0);
        check("por_dma", int'(bus.int_start_dma), 0);
        repeat (2) @(posedge clk);
        #2 res = 1'b0;

        // idle after release: no pulses
        repeat (8) tick();
        drain();
        check("idle_pulses", cnt_frm + cnt_lin + cnt_dma, 0);

        // frame INT at (line 5, hcnt 0x10) with full hcnt sweeps
        wr(3'd0, 8'h10);
        wr(3'd1, 8'h05);
        wr(3'd2, 8'h00);
        drain();
        cnt_frm = 0;
        run_line(1'b1, 256);
        for (int l = 1; l <= 5; l++) run_line(1'b0, 256);
        run_line(1'b0, 32);
        drain();
        check("frm_once", cnt_frm, 1);

        // VSINT=0x150 is beyond the frame: never fires; line counter wraps
        wr(3'd1, 8'h50);
        wr(3'd2, 8'hFF);
        drain();
        cnt_frm = 0;
        run_line(1'b1, 4);
        for (int l = 1; l < 2 * VTOTAL; l++) begin
            run_line(1'b0, 4);
            if (l == VTOTAL - 1) begin
                drain();
                check("vline_last", int'(bus.vline), VTOTAL - 1);
            end
            if (l == VTOTAL) begin
                drain();
                check("vline_wrap", int'(bus.vline), 0);
            end
        end
        drain();
        check("frm_suppressed", cnt_frm, 0);

        // line-INT decimation (LSTEP=2)
        wr(3'd4, 8'h02);
        drain();
        cnt_lin = 0;
        run_line(1'b1, 3);
        for (int l = 1; l <= 9; l++) run_line(1'b0, 3);
        drain();
        check("lin_step", cnt_lin, LIN_EXP);

        // DMA: held high gives one pulse per rising edge
        drain();
        cnt_dma = 0;
        s_dma = 1'b1;
        repeat (50) tick();
        s_dma = 1'b0;
        repeat (10) tick();
        s_dma = 1'b1;
        repeat (10) tick();
        s_dma = 1'b0;
        tick();
        drain();
        check("dma_two", cnt_dma, 2);

        // all three strobes in the same cycle at line 0 / hcnt 0
        s_hcnt = 8'd200;
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        s_fs = 1'b1;
        s_ls = 1'b1;
        tick();
        repeat (3) tick();
        s_fs = 1'b1;
        s_ls = 1'b1;
        s_hcnt = 8'd0;
        s_dma = 1'b1;
        tick();
        drain();
        check("sim_frm", int'(bus.int_start_frm), 1);
        check("sim_lin", int'(bus.int_start_lin), 1);
        check("sim_dma", int'(bus.int_start_dma), 1);
        check("sim_vline", int'(bus.vline), 0);
        s_hcnt = 8'd200;
        s_dma = 1'b0;

        // asynchronous reset mid-cycle while state is non-default
        wr(3'd3, 8'hA5);
        run_line(1'b0, 2);
        run_line(1'b0, 2);
        run_line(1'b0, 1);
        drain();
        res = 1'b1;
        #1;
        check("arst_vline", int'(bus.vline), 0);
        check("arst_intmask", int'(bus.intmask), 1);
        check("arst_frm", int'(bus.int_start_frm), 0);
        check("arst_lin", int'(bus.int_start_lin), 0);
        check("arst_dma", int'(bus.int_start_dma), 0);
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        s_hcnt = 8'd200;
        res = 1'b0;
        repeat (4) tick();

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                s_fs = 1'b1;
                s_ls = 1'b1;
                s_hcnt = 8'd0;
            end else if ($urandom_range(0, 7) == 0) begin
                s_ls = 1'b1;
                s_hcnt = 8'd0;
            end else begin
                s_hcnt = s_hcnt + 8'd1;
            end
            if ($urandom_range(0, 19) == 0) s_dma = !s_dma;
            if ($urandom_range(0, 29) == 0) begin
                s_we = 1'b1;
                s_wa = 3'($urandom_range(0, 7));
                case (s_wa)
                    3'd0:    s_wd = 8'($urandom_range(0, 9));
                    3'd1:    s_wd = 8'($urandom_range(0, 15));
                    3'd2:    s_wd = (8'($urandom) & 8'hFE) | (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
                    3'd4:    s_wd = 8'($urandom_range(0, 4));
                    default: s_wd = 8'($urandom);
                endcase
            end
            tick();
        end
        drain();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
